line_output_sched: RTL and testbench

LINE_OUTPUT_SCHED -- requirements
Module: line_output_sched

---
 rtl/line_output_sched.sv | 126 ++++++++++++
 tb/tb_line_output_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_output_sched.sv
// Line output scheduler: shared strobe generator (delay/width FSM) with miss
// counting, plus a registered per-line source mux for three output lines.
module line_output_sched #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_trigger,
    input  logic                 i_exposure_active,
    input  logic [2:0]           iv_user_output,
    input  logic [1:0]           iv_line1_src,
    input  logic [1:0]           iv_line2_src,
    input  logic [1:0]           iv_line3_src,
    input  logic                 i_strobe_en,
    input  logic [CNT_WIDTH-1:0] iv_strobe_delay,
    input  logic [CNT_WIDTH-1:0] iv_strobe_width,
    input  logic                 i_miss_clr,
    output logic [2:0]           ov_lineout,
    output logic                 o_strobe_busy,
    output logic [7:0]           ov_miss_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PULSE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [CNT_WIDTH-1:0] width_lat, width_next;
    logic                 strobe;
    logic                 exposure_q;
    logic                 miss;
    logic [2:0]           line_next;

    function automatic logic pick(input logic [1:0] src, input logic user_bit,
                                  input logic exp_bit, input logic strobe_bit);
        case (src)
            2'd0:    pick = user_bit;
            2'd1:    pick = exp_bit;
            2'd2:    pick = strobe_bit;
            default: pick = 1'b0;
        endcase
    endfunction

    assign miss          = (state != IDLE) && i_strobe_en && i_trigger;
    assign o_strobe_busy = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        width_next = width_lat;
        case (state)
            IDLE: begin
                // A zero-width request is accepted but produces nothing.
                if (i_trigger && i_strobe_en && iv_strobe_width != '0) begin
                    width_next = iv_strobe_width;
                    if (iv_strobe_delay == '0) begin
                        state_next = PULSE;
                        cnt_next   = iv_strobe_width - ONE;
                    end else begin
                        state_next = DELAY;
                        cnt_next   = iv_strobe_delay - ONE;
                    end
                end
            end
            DELAY: begin
                if (!i_strobe_en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = PULSE;
                    cnt_next   = width_lat - ONE;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            PULSE: begin
                if (!i_strobe_en || cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        line_next = {pick(iv_line3_src, iv_user_output[2], exposure_q, strobe),
                     pick(iv_line2_src, iv_user_output[1], exposure_q, strobe),
                     pick(iv_line1_src, iv_user_output[0], exposure_q, strobe)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            width_lat   <= '0;
            strobe      <= 1'b0;
            exposure_q  <= 1'b0;
            ov_lineout  <= '0;
            ov_miss_cnt <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            width_lat  <= width_next;
            strobe     <= (state_next == PULSE);
            exposure_q <= i_exposure_active;
            ov_lineout <= line_next;
            // Clear wins over the old value but not over a coincident miss.
            if (i_miss_clr)
                ov_miss_cnt <= miss ? 8'd1 : 8'd0;
            else if (miss && ov_miss_cnt != '1)
                ov_miss_cnt <= ov_miss_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_line_output_sched.sv
// Scoreboard bench for line_output_sched: a window-based reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_line_output_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic        expo;
    logic [2:0]  user;
    logic [1:0]  sel1, sel2, sel3;
    logic        en;
    logic [15:0] dly, wid;
    logic        clr;
    logic [2:0]  lineout;
    logic        busy;
    logic [7:0]  miss_cnt;

    always #5 clk = ~clk;

    line_output_sched #(.CNT_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (rst),
        .i_trigger         (trig),
        .i_exposure_active (expo),
        .iv_user_output    (user),
        .iv_line1_src      (sel1),
        .iv_line2_src      (sel2),
        .iv_line3_src      (sel3),
        .i_strobe_en       (en),
        .iv_strobe_delay   (dly),
        .iv_strobe_width   (wid),
        .i_miss_clr        (clr),
        .ov_lineout        (lineout),
        .o_strobe_busy     (busy),
        .ov_miss_cnt       (miss_cnt)
    );

    typedef struct {
        logic [2:0] line;
        logic       busy;
        logic [7:0] miss;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: busy and strobe are closed cycle windows [from, to].
    int   m_cyc  = 0;
    int   bf = 0, bt = -1, sf = 0, st = -1;
    int   m_miss = 0;
    logic m_exp  = 1'b0;

    function automatic logic in_win(input int c, input int f, input int t);
        return (c >= f) && (c <= t);
    endfunction

    function automatic logic src_val(input logic [1:0] s, input logic u,
                                     input logic e, input logic p);
        if (s == 2'd0) return u;
        if (s == 2'd1) return e;
        if (s == 2'd2) return p;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        logic str_prev, busy_prev, miss_ev;
        logic [2:0] line;
        m_cyc++;
        str_prev  = in_win(m_cyc - 1, sf, st);
        busy_prev = in_win(m_cyc - 1, bf, bt);
        line = '0;
        if (rst) begin
            bf = 0; bt = -1; sf = 0; st = -1;
            m_miss = 0;
            m_exp  = 1'b0;
        end else begin
            miss_ev = busy_prev && en && trig;
            line[0] = src_val(sel1, user[0], m_exp, str_prev);
            line[1] = src_val(sel2, user[1], m_exp, str_prev);
            line[2] = src_val(sel3, user[2], m_exp, str_prev);
            m_exp = expo;
            if (busy_prev && !en) begin
                bt = m_cyc - 1;
                if (st > m_cyc - 1) st = m_cyc - 1;
            end else if (trig && en && !busy_prev && wid != 0) begin
                bf = m_cyc;
                bt = m_cyc + int'(dly) + int'(wid) - 1;
                sf = m_cyc + int'(dly);
                st = bt;
            end
            if (clr) m_miss = miss_ev ? 1 : 0;
            else if (miss_ev && m_miss < 255) m_miss++;
        end
        e.line = line;
        e.busy = in_win(m_cyc, bf, bt);
        e.miss = 8'(m_miss);
        e.cyc  = m_cyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("lineout@%0d", e.cyc), int'(lineout), int'(e.line));
            chk($sformatf("busy@%0d", e.cyc), int'(busy), int'(e.busy));
            chk($sformatf("miss_cnt@%0d", e.cyc), int'(miss_cnt), int'(e.miss));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        trig = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        int cnt_line, cnt_busy, miss_before;
        rst = 1'b1; trig = 1'b0; expo = 1'b0; user = 3'b000;
        sel1 = 2'd3; sel2 = 2'd3; sel3 = 2'd3;
        en = 1'b1; dly = 16'd0; wid = 16'd0; clr = 1'b0;
        repeat (3) tick();
        chk("reset_lineout", int'(lineout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_miss", int'(miss_cnt), 0);
        rst = 1'b0;

        // Basic strobe on line2, D=3 W=5.
        sel2 = 2'd2; dly = 16'd3; wid = 16'd5; trig = 1'b1;
        tick();
        cnt_line = 0; cnt_busy = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt_line += int'(lineout[1]);
            cnt_busy += int'(busy);
        end
        chk("basic_line_cycles", cnt_line, 5);
        chk("basic_busy_cycles", cnt_busy, 8);

        // D=0 W=1 gives a single line cycle.
        dly = 16'd0; wid = 16'd1; trig = 1'b1;
        tick();
        cnt_line = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt_line += int'(lineout[1]);
        end
        chk("d0w1_line_cycles", cnt_line, 1);

        // W=0: nothing happens.
        miss_before = int'(miss_cnt);
        dly = 16'd2; wid = 16'd0; trig = 1'b1;
        tick();
        cnt_busy = int'(busy);
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt_busy += int'(busy);
        end
        chk("w0_busy_cycles", cnt_busy, 0);
        chk("w0_miss", int'(miss_cnt), miss_before);

        // Misses: triggers at T, T+4, T+19 with D=W=10.
        dly = 16'd10; wid = 16'd10;
        for (int i = 0; i < 30; i++) begin
            trig = (i == 0 || i == 4 || i == 19);
            tick();
        end
        chk("miss_two", int'(miss_cnt), 2);
        clr = 1'b1;
        tick();
        chk("miss_clr", int'(miss_cnt), 0);
        dly = 16'd200; wid = 16'd200; trig = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            trig = 1'b1;
            tick();
        end
        chk("miss_saturate", int'(miss_cnt), 255);
        trig = 1'b1; clr = 1'b1;
        tick();
        chk("miss_clr_with_miss", int'(miss_cnt), 1);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();

        // Abort by dropping enable at T+5 of a D=2 W=20 pulse.
        dly = 16'd2; wid = 16'd20; trig = 1'b1;
        tick();
        repeat (4) tick();
        chk("abort_line_before", int'(lineout[1]), 1);
        en = 1'b0;
        tick();
        chk("abort_busy", int'(busy), 0);
        tick();
        chk("abort_line", int'(lineout[1]), 0);
        en = 1'b1;
        tick();

        // Reset mid-PULSE, then trigger in the first cycle after reset.
        dly = 16'd1; wid = 16'd20; trig = 1'b1;
        tick();
        repeat (5) tick();
        rst = 1'b1; trig = 1'b1;
        tick();
        chk("rst_mid_lineout", int'(lineout), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_miss", int'(miss_cnt), 0);
        rst = 1'b0; dly = 16'd0; wid = 16'd3; trig = 1'b1;
        tick();
        chk("first_trig_after_rst", int'(busy), 1);
        repeat (6) tick();

        // Source mux: user/exposure/zero, then a source change.
        user = 3'b101; sel1 = 2'd0; sel2 = 2'd1; sel3 = 2'd3;
        for (int i = 0; i < 12; i++) begin
            expo = i[1];
            tick();
        end
        sel1 = 2'd3; sel3 = 2'd0;
        tick();
        tick();
        chk("mux_change", int'(lineout[0]) + 2 * int'(lineout[2]), 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                sel1 = 2'($urandom); sel2 = 2'($urandom); sel3 = 2'($urandom);
                user = 3'($urandom);
            end
            expo = 1'($urandom);
            en   = ($urandom_range(0, 9) != 0);
            trig = ($urandom_range(0, 9) < 3);
            clr  = ($urandom_range(0, 29) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            dly  = 16'($urandom_range(0, 6));
            wid  = 16'($urandom_range(0, 6));
            tick();
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
